nanov_alu_seq: RTL
==================

Name: nanov_alu_seq

Overview:
- Bit-serial operand sequencer and result collector: the driving end of the nanoV serial ALU interface.
- Accepts two parallel XLEN-bit operands and an ALU op, then streams operand bits LSB-first into the serial ALU one bit per cycle.
- Carries the ALU carry between cycles, reassembles the returned result bits, and on the final bit derives the SLT/SLTU result.
- Sits between the register file/decoder and the serial ALU in the nanoV datapath.

Parameters:
XLEN, 32, operand/result width and number of serial cycles per operation (>=2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request new operation; accepted only in IDLE
op  input  4  ALU op: 0000 ADD, 1000 SUB, 0010 SLT, 0011 SLTU, 0111 AND, 0110 OR, 0100 XOR
a_in  input  XLEN  operand A, sampled on accepted start
b_in  input  XLEN  operand B, sampled on accepted start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse: result valid
result  output  XLEN  last completed result, held until next completion
alu_op  output  4  op latched at start, to serial ALU
alu_a  output  1  current A bit
alu_b  output  1  current B bit
alu_cy_in  output  1  carry into current bit
alu_d  input  1  serial ALU result bit
alu_cy_out  input  1  serial ALU carry out
alu_lts  input  1  serial ALU signed-less-than, valid on final bit

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: state IDLE; busy 0, done 0, result 0, alu_op 0, alu_a 0, alu_b 0, alu_cy_in 0; bit counter 0; shift registers 0.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - alu_a/alu_b/alu_cy_in driven 0.
  - On start=1 at edge E0: latch a_in->a_sr, b_in->b_sr, op->alu_op; cnt<=0; cy<=op[1]|op[3]; go to RUN.
  - The ALU inverts B for SUB/SLT/SLTU, so the initial carry-in of 1 forms A-B.
- RUN:
  - alu_a=a_sr[0], alu_b=b_sr[0], alu_cy_in=cy.
  - Each edge: a_sr/b_sr shift right by 1; res_sr shifts right with alu_d entering at MSB; cy<=alu_cy_out; cnt<=cnt+1.
  - Final bit, edge where cnt==XLEN-1 (edge E_XLEN): go to DONE and write result:
    - ADD/SUB/AND/OR/XOR: {alu_d, res_sr[XLEN-1:1]}, i.e. the complete reassembled word.
    - SLT (op[2:0]==010, op[3]=0): zero-extended alu_lts.
    - SLTU (op==0011): zero-extended ~alu_cy_out (carry out 1 means A>=B unsigned).
- DONE: done=1 for exactly this cycle; busy=1; next edge -> IDLE. start is ignored in DONE.
- Latency: done is high in the cycle following edge E0+XLEN (XLEN edges after the accepting edge). Back-to-back start in the first IDLE cycle after DONE is legal; throughput is one op per XLEN+2 cycles.
- start while busy: ignored. Operands, op and the in-flight result are unaffected.
- result changes only at the final-bit edge; stable otherwise, including throughout the next op's RUN.
- Reset mid-operation: next state is IDLE with all reset values (result cleared); no done pulse.
- Undefined op codes: streamed normally; result content unspecified (not checked).
- cnt width is clog2(XLEN); there is no wrap, since cnt leaves RUN at XLEN-1.

Optional Feature:
NANOV_ALU_SEQ_CMP_OUT_EN
- Defined: adds outputs cmp_lts (1) and cmp_ltu (1), registered at the final-bit edge as alu_lts and ~alu_cy_out for every op. Both hold until the next completion and reset to 0. They are meaningful only when op[1]|op[3]; this allows branch compare from a single SUB pass.
- Undefined: ports and registers absent; behaviour otherwise identical.

Test Plan:
- ADD a=0x7FFFFFFF b=0x00000001, start at E0 -> busy from E0; done single pulse in the cycle after E0+32; result 0x80000000; alu_cy_in 0 on bit 0.
- SUB a=5 b=7 -> result 0xFFFFFFFE; alu_cy_in 1 on bit 0.
- SLT a=0xFFFFFFFF b=1 -> result 1. SLTU same operands -> result 0. SLTU a=3 b=5 -> result 1.
- AND/OR/XOR with a=0xF0F0A5A5 b=0xFF00FF00 -> 0xF000A500 / 0xFFF0FFA5 / 0x0FF05AA5; result holds across the following op's RUN.
- Pulse start with new operands at bit 10 of a running ADD -> ignored, original result produced. Assert rst at bit 20 of the next op -> busy 0 and result 0 next cycle, no done; a subsequent ADD 2+3 gives 5.
- With NANOV_ALU_SEQ_CMP_OUT_EN, SUB a=3 b=5 -> result 0xFFFFFFFE, cmp_lts 1, cmp_ltu 1. SUB a=0x80000000 b=1 -> cmp_lts 1, cmp_ltu 0.

Source files
------------

// File: rtl/nanov_alu_seq.sv
// Bit-serial operand sequencer / result collector driving the nanoV serial ALU.
// Optional compare outputs (cmp_lts, cmp_ltu) enabled by NANOV_ALU_SEQ_CMP_OUT_EN.
module nanov_alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [3:0]      alu_op,
    output logic            alu_a,
    output logic            alu_b,
    output logic            alu_cy_in,
    input  logic            alu_d,
    input  logic            alu_cy_out,
    input  logic            alu_lts
`ifdef NANOV_ALU_SEQ_CMP_OUT_EN
    ,
    output logic            cmp_lts,
    output logic            cmp_ltu
`endif
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            cy;
    logic [XLEN-1:0] a_sr, b_sr, res_sr;
    logic            last_bit;
    logic            is_slt, is_sltu;

    assign last_bit = (cnt == CW'(XLEN - 1));
    assign is_slt   = (alu_op[3] == 1'b0) && (alu_op[2:0] == 3'b010);
    assign is_sltu  = (alu_op == 4'b0011);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        alu_a     = 1'b0;
        alu_b     = 1'b0;
        alu_cy_in = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy      = 1'b1;
                alu_a     = a_sr[0];
                alu_b     = b_sr[0];
                alu_cy_in = cy;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            cnt     <= '0;
            cy      <= 1'b0;
            alu_op  <= '0;
            result  <= '0;
`ifdef NANOV_ALU_SEQ_CMP_OUT_EN
            cmp_lts <= 1'b0;
            cmp_ltu <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a_in;
                        b_sr   <= b_in;
                        alu_op <= op;
                        cnt    <= '0;
                        // ALU inverts B for subtract-type ops; carry-in 1 completes A-B.
                        cy     <= op[1] | op[3];
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {alu_d, res_sr[XLEN-1:1]};
                    cy     <= alu_cy_out;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        if (is_slt)
                            result <= {{(XLEN-1){1'b0}}, alu_lts};
                        else if (is_sltu)
                            result <= {{(XLEN-1){1'b0}}, ~alu_cy_out};
                        else
                            result <= {alu_d, res_sr[XLEN-1:1]};
`ifdef NANOV_ALU_SEQ_CMP_OUT_EN
                        cmp_lts <= alu_lts;
                        cmp_ltu <= ~alu_cy_out;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
